// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// width codes and error cause encodings.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ERR_LD_MISALIGN = 2'd0,
    ERR_ST_MISALIGN = 2'd1,
    ERR_TIMEOUT     = 2'd2,
    ERR_ILLEGAL     = 2'd3
  } lsu_err_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: op legality/alignment checks, store byte-enable
// and data replication, and load byte/halfword extraction with extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        op_read,
  input  logic        op_write,
  input  logic [2:0]  op_funct3,
  input  logic [1:0]  op_offset,
  input  logic [31:0] op_wdata,
  output logic [3:0]  req_be,
  output logic [31:0] req_wdata,
  output logic        illegal,
  output logic        misaligned,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = rdata[8*gi +: 8];
  end

  always_comb begin
    illegal = 1'b0;
    if (op_read && op_write) begin
      illegal = 1'b1;
    end else if (op_read) begin
      illegal = !(op_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    end else if (op_write) begin
      illegal = !(op_funct3 inside {F3_SB, F3_SH, F3_SW});
    end
  end

  // Access width comes from the low two funct3 bits for both loads and stores.
  always_comb begin
    misaligned = 1'b0;
    case (op_funct3[1:0])
      2'b01:   misaligned = op_offset[0];
      2'b10:   misaligned = |op_offset;
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    req_be    = 4'b1111;
    req_wdata = op_wdata;
    if (op_write) begin
      case (op_funct3[1:0])
        2'b00: begin
          req_be    = 4'b0001 << op_offset;
          req_wdata = {4{op_wdata[7:0]}};
        end
        2'b01: begin
          req_be    = 4'b0011 << op_offset;
          req_wdata = {2{op_wdata[15:0]}};
        end
        default: begin
          req_be    = 4'b1111;
          req_wdata = op_wdata;
        end
      endcase
    end
  end

  assign byte_sel = lane[ld_offset];
  assign half_sel = ld_offset[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};

  always_comb begin
    ld_data = rdata;
    case (ld_funct3)
      F3_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  ld_data = {24'd0, byte_sel};
      F3_LHU:  ld_data = {16'd0, half_sel};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: accepts one load/store from the core, runs a single
// bus transaction (request/grant, then read response for loads) and reports errors.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        st_done,
  output logic        err_valid,
  output logic [1:0]  err_cause
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ex_ready_reg, ex_ready_next;
  logic             bus_req_reg, bus_req_next;
  logic             bus_we_reg, bus_we_next;
  logic [31:0]      bus_addr_reg, bus_addr_next;
  logic [3:0]       bus_be_reg, bus_be_next;
  logic [31:0]      bus_wdata_reg, bus_wdata_next;
  logic             wb_valid_reg, wb_valid_next;
  logic [31:0]      wb_data_reg, wb_data_next;
  logic             st_done_reg, st_done_next;
  logic             err_valid_reg, err_valid_next;
  logic [1:0]       err_cause_reg, err_cause_next;
  logic [2:0]       ld_funct3_reg, ld_funct3_next;
  logic [1:0]       ld_offset_reg, ld_offset_next;

  logic [3:0]       req_be;
  logic [31:0]      req_wdata;
  logic             illegal;
  logic             misaligned;
  logic [31:0]      ld_data;

  lsu_lane_align u_align (
    .op_read    (mem_read),
    .op_write   (mem_write),
    .op_funct3  (funct3),
    .op_offset  (addr[1:0]),
    .op_wdata   (wdata),
    .req_be     (req_be),
    .req_wdata  (req_wdata),
    .illegal    (illegal),
    .misaligned (misaligned),
    .ld_funct3  (ld_funct3_reg),
    .ld_offset  (ld_offset_reg),
    .rdata      (bus_rdata),
    .ld_data    (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      ex_ready_reg  <= 1'b1;
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= '0;
      bus_be_reg    <= '0;
      bus_wdata_reg <= '0;
      wb_valid_reg  <= 1'b0;
      wb_data_reg   <= '0;
      st_done_reg   <= 1'b0;
      err_valid_reg <= 1'b0;
      err_cause_reg <= '0;
      ld_funct3_reg <= '0;
      ld_offset_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      ex_ready_reg  <= ex_ready_next;
      bus_req_reg   <= bus_req_next;
      bus_we_reg    <= bus_we_next;
      bus_addr_reg  <= bus_addr_next;
      bus_be_reg    <= bus_be_next;
      bus_wdata_reg <= bus_wdata_next;
      wb_valid_reg  <= wb_valid_next;
      wb_data_reg   <= wb_data_next;
      st_done_reg   <= st_done_next;
      err_valid_reg <= err_valid_next;
      err_cause_reg <= err_cause_next;
      ld_funct3_reg <= ld_funct3_next;
      ld_offset_reg <= ld_offset_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bus_req_next   = bus_req_reg;
    bus_we_next    = bus_we_reg;
    bus_addr_next  = bus_addr_reg;
    bus_be_next    = bus_be_reg;
    bus_wdata_next = bus_wdata_reg;
    wb_valid_next  = 1'b0;
    wb_data_next   = wb_data_reg;
    st_done_next   = 1'b0;
    err_valid_next = 1'b0;
    err_cause_next = err_cause_reg;
    ld_funct3_next = ld_funct3_reg;
    ld_offset_next = ld_offset_reg;

    case (state_reg)
      IDLE: begin
        if (ex_valid && (mem_read || mem_write)) begin
          if (illegal) begin
            err_valid_next = 1'b1;
            err_cause_next = ERR_ILLEGAL;
          end else if (misaligned) begin
            err_valid_next = 1'b1;
            err_cause_next = mem_write ? ERR_ST_MISALIGN : ERR_LD_MISALIGN;
          end else begin
            state_next     = REQ;
            bus_req_next   = 1'b1;
            bus_we_next    = mem_write;
            bus_addr_next  = {addr[31:2], 2'b00};
            bus_be_next    = req_be;
            bus_wdata_next = req_wdata;
            ld_funct3_next = funct3;
            ld_offset_next = addr[1:0];
          end
        end
      end
      // Grant wait is unbounded; the bus arbiter guarantees forward progress.
      REQ: begin
        if (bus_gnt) begin
          bus_req_next = 1'b0;
          if (bus_we_reg) begin
            st_done_next = 1'b1;
            state_next   = IDLE;
          end else begin
            cnt_next   = '0;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus_rvalid) begin
          wb_valid_next = 1'b1;
          wb_data_next  = ld_data;
          state_next    = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          err_valid_next = 1'b1;
          err_cause_next = ERR_TIMEOUT;
          state_next     = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    ex_ready_next = (state_next == IDLE);
  end

  assign ex_ready  = ex_ready_reg;
  assign bus_req   = bus_req_reg;
  assign bus_we    = bus_we_reg;
  assign bus_addr  = bus_addr_reg;
  assign bus_be    = bus_be_reg;
  assign bus_wdata = bus_wdata_reg;
  assign wb_valid  = wb_valid_reg;
  assign wb_data   = wb_data_reg;
  assign st_done   = st_done_reg;
  assign err_valid = err_valid_reg;
  assign err_cause = err_cause_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized + directed bench for load_store_unit; expectations come from an
// arithmetic model of the RV32I access rules.
module tb_load_store_unit;

  localparam int TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        wb_valid, st_done, err_valid;
  logic [31:0] wb_data;
  logic [1:0]  err_cause;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .st_done(st_done),
    .err_valid(err_valid), .err_cause(err_cause)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---- reference model ----
  function automatic int op_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_illegal(input bit rd, input bit wr, input logic [2:0] f3);
    int f = int'(f3);
    if (rd && wr) return 1'b1;
    if (rd) return (f == 3 || f == 6 || f == 7);
    return (f == 3 || f >= 4);
  endfunction

  function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) % op_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    int m;
    if (!wr) return 4'hF;
    m = ((1 << op_size(f3)) - 1) << int'(a[1:0]);
    return 4'(m);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (op_size(f3))
      1:       return 32'(wd & 32'hFF) * 32'h0101_0101;
      2:       return 32'(wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
    int     sz = op_size(f3);
    longint v;
    v = (longint'(word) >> (8 * int'(a[1:0]))) & ((64'd1 << (8 * sz)) - 1);
    if (int'(f3) < 4 && sz < 4 && v >= (64'd1 << (8 * sz - 1)))
      v = v - (64'd1 << (8 * sz));
    return v[31:0];
  endfunction

  // Call at a negedge; returns at the negedge where the result is visible.
  task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int gnt_dly, input int rv_dly, input logic [31:0] rword);
    logic [31:0] e_addr;
    check("idle_rdy", 32'(ex_ready), 32'd1);
    ex_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    if (!rd && !wr) begin
      check("nop_req", 32'(bus_req), 32'd0);
      check("nop_err", 32'(err_valid), 32'd0);
      $display("TXN nop addr=%08h", a);
      return;
    end
    if (is_illegal(rd, wr, f3) || is_misaligned(f3, a)) begin
      check("err_valid", 32'(err_valid), 32'd1);
      check("err_cause", 32'(err_cause), is_illegal(rd, wr, f3) ? 32'd3 : (wr ? 32'd1 : 32'd0));
      check("err_noreq", 32'(bus_req), 32'd0);
      $display("TXN err rd=%0d wr=%0d f3=%0d addr=%08h cause=%0d", rd, wr, f3, a, err_cause);
      return;
    end
    e_addr = {a[31:2], 2'b00};
    for (int i = 0; i <= gnt_dly; i++) begin
      check("req_hi", 32'(bus_req), 32'd1);
      check("req_we", 32'(bus_we), 32'(wr));
      check("req_addr", bus_addr, e_addr);
      check("req_be", 32'(bus_be), 32'(exp_be(wr, f3, a)));
      if (wr) check("req_wdata", bus_wdata, exp_wdata(f3, wd));
      check("req_busy", 32'(ex_ready), 32'd0);
      check("req_pulse", 32'({wb_valid, st_done, err_valid}), 32'd0);
      bus_gnt    = (i == gnt_dly);
      bus_rvalid = (i < gnt_dly) ? 1'($urandom) : 1'b0;
      bus_rdata  = $urandom;
      @(negedge clk);
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    check("gnt_req_lo", 32'(bus_req), 32'd0);
    if (wr) begin
      check("st_done", 32'(st_done), 32'd1);
      check("st_rdy", 32'(ex_ready), 32'd1);
      $display("TXN store f3=%0d addr=%08h be=%h wdata=%08h", f3, a, bus_be, bus_wdata);
      return;
    end
    check("ld_nodone", 32'({st_done, wb_valid}), 32'd0);
    for (int i = 0; i <= rv_dly; i++) begin
      bus_rvalid = (i == rv_dly);
      bus_rdata  = (i == rv_dly) ? rword : $urandom;
      @(negedge clk);
      if (i < rv_dly) begin
        check("wait_pulse", 32'({wb_valid, err_valid}), 32'd0);
        check("wait_busy", 32'(ex_ready), 32'd0);
      end
    end
    bus_rvalid = 1'b0;
    check("wb_valid", 32'(wb_valid), 32'd1);
    check("wb_data", wb_data, exp_load(f3, a, rword));
    check("wb_rdy", 32'(ex_ready), 32'd1);
    $display("TXN load f3=%0d addr=%08h rword=%08h wb=%08h", f3, a, rword, wb_data);
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
    addr = '0; wdata = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_req", 32'({bus_req, bus_we, wb_valid, st_done, err_valid}), 32'd0);
    check("rst_bus", bus_addr | bus_wdata | 32'(bus_be), 32'd0);
    check("rst_wb", wb_data | 32'(err_cause), 32'd0);
    check("rst_rdy", 32'(ex_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    do_op(0, 1, 3'b000, 32'h103, 32'hAB, 0, 0, 0);
    do_op(1, 0, 3'b000, 32'h102, 0, 0, 0, 32'h1280_3456);
    check("lb_const", wb_data, 32'hFFFF_FF80);
    do_op(1, 0, 3'b100, 32'h102, 0, 0, 0, 32'h1280_3456);
    do_op(1, 0, 3'b001, 32'h102, 0, 0, 0, 32'h1280_3456);
    do_op(1, 0, 3'b010, 32'h102, 0, 0, 0, 0);
    do_op(0, 1, 3'b001, 32'h101, 0, 0, 0, 0);
    do_op(1, 0, 3'b011, 32'h100, 0, 0, 0, 0);
    do_op(1, 1, 3'b010, 32'h100, 0, 0, 0, 0);
    do_op(1, 0, 3'b001, 32'h2002, 0, 3, 2, 32'hC0DE_8001);
    do_op(0, 1, 3'b010, 32'h300, 32'hDEAD_BEEF, 0, 0, 0);

    // Timeout: no rvalid, then a late rvalid must be ignored
    do_op(0, 0, 3'b000, 0, 0, 0, 0, 0);
    ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400;
    @(negedge clk);
    ex_valid = 1'b0; mem_read = 1'b0; bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    for (int i = 0; i < TB_TIMEOUT; i++) begin
      @(negedge clk);
      if (i < TB_TIMEOUT - 1) check("to_early", 32'(err_valid), 32'd0);
    end
    check("to_err", 32'(err_valid), 32'd1);
    check("to_cause", 32'(err_cause), 32'd2);
    check("to_rdy", 32'(ex_ready), 32'd1);
    bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
    @(negedge clk);
    bus_rvalid = 1'b0;
    check("to_late", 32'({wb_valid, err_valid}), 32'd0);
    $display("TXN timeout addr=00000400");

    // Reset during REQ: bus_req drops without a clock edge
    ex_valid = 1'b1; mem_write = 1'b1; funct3 = 3'b010; addr = 32'h500;
    @(negedge clk);
    ex_valid = 1'b0; mem_write = 1'b0;
    check("rq_req", 32'(bus_req), 32'd1);
    #2 rst = 1'b1;
    #1 check("rq_rst_req", 32'(bus_req), 32'd0);
    check("rq_rst_rdy", 32'(ex_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0; bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    check("rq_late_gnt", 32'({st_done, bus_req}), 32'd0);
    $display("TXN reset_in_req");

    // Reset during WAIT: following rvalid gives no wb_valid
    ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b000; addr = 32'h600;
    @(negedge clk);
    ex_valid = 1'b0; mem_read = 1'b0; bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    #2 rst = 1'b1;
    #1 check("wt_rst_pulses", 32'({bus_req, wb_valid, st_done, err_valid}), 32'd0);
    @(negedge clk);
    rst = 1'b0; bus_rvalid = 1'b1;
    @(negedge clk);
    bus_rvalid = 1'b0;
    check("wt_late_rv", 32'(wb_valid), 32'd0);
    check("wt_rdy", 32'(ex_ready), 32'd1);
    $display("TXN reset_in_wait");

    // Randomized back-to-back traffic
    for (int n = 0; n < 300; n++) begin
      int sel = $urandom_range(0, 9);
      bit rd = (sel >= 2 && sel < 6) || sel == 1;
      bit wr = sel >= 6 || sel == 1;
      logic [31:0] a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      do_op(rd, wr, 3'($urandom), a, $urandom,
            $urandom_range(0, 3), $urandom_range(0, TB_TIMEOUT - 1), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
